sort_buffer: RTL and testbench
==============================

Name: sort_buffer

Overview:
- Parametrised hardware sort buffer: accepts up to DEPTH unsigned words over a valid/ready stream, sorts them on command, and streams the result out in ascending or descending order.
- Loading may be split across several bursts before sorting, so a partial fill can be extended up to capacity.
- Sits between a random-stimulus or data-source stage and any consumer that needs ordered data.

Parameters:
- DATA_W, 32, width of each element in bits (unsigned).
- DEPTH, 16, maximum element count; must be >= 2.
- CNT_W, $clog2(DEPTH+1), width of the count output (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  buffer can accept an element.
- in_data  in  DATA_W  input element.
- start  in  1  single-cycle pulse that begins the sort of the current contents.
- descending  in  1  sort order, sampled on the start cycle: 0 ascending, 1 descending.
- busy  out  1  high while the state is SORT or DRAIN.
- count  out  CNT_W  number of elements currently held.
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts the output element.
- out_data  out  DATA_W  output element.
- out_last  out  1  marks the final element of the drain.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to LOAD; count=0.
  - in_ready=1, busy=0, out_valid=0, out_last=0, out_data=0.
  - Storage contents are don't-care.
- LOAD state:
  - in_ready = (count < DEPTH).
  - Each in_valid & in_ready cycle writes in_data to slot[count] and increments count. There is no upper bound other than DEPTH.
  - in_valid while count==DEPTH is ignored; in_ready is 0 and nothing is written.
  - start with count>=2: latch descending into the order register, go to SORT next cycle, drop in_ready.
  - start with count==1: skip SORT and go directly to DRAIN.
  - start with count==0: ignored; stay in LOAD.
  - start and an accepted write in the same cycle: the write is included in the sort.
- SORT state:
  - Odd-even transposition sort, exactly DEPTH cycles, one pass per cycle.
  - Even passes compare pairs (0,1),(2,3)…; odd passes compare pairs (1,2),(3,4)…; all pairs in a pass operate in parallel.
  - A pair (i,i+1) swaps only if i+1 < count and it is out of order for the latched direction.
  - Slots >= count are never touched.
  - Equal values are never swapped.
  - A pass counter runs 0..DEPTH-1. Transition to DRAIN when the counter reaches DEPTH-1.
  - Latency is fixed: DRAIN is entered DEPTH+1 cycles after the start cycle.
  - in_ready=0 and start is ignored throughout SORT.
- DRAIN state:
  - out_valid=1, out_data=slot[rd_ptr], out_last=(rd_ptr==count-1). rd_ptr begins at 0.
  - out_data is registered. It is stable while out_valid & !out_ready, and it advances only on out_valid & out_ready.
  - On the handshake with out_last=1: count returns to 0, rd_ptr returns to 0, out_valid goes to 0 next cycle, state returns to LOAD, in_ready returns to 1.
  - start and in_valid are ignored during DRAIN.
- busy = state is SORT or DRAIN.
- count is held constant during SORT and DRAIN.
- Reset asserted mid-SORT or mid-DRAIN aborts immediately to the reset values; no partial output follows reset release.
- Comparisons are unsigned over the full DATA_W bits, with no truncation.

Test Plan:
- Reset and basic load:
  - Reset, then load 10 values {4,80,13,27,35,67,31,43,67,42}, then load 5 more {72,75,84,36,14}, then start with descending=0.
  - Required: count=15 before start; out_valid rises exactly 17 cycles after the start cycle (DEPTH=16).
  - Required output, in order: 4,13,14,27,31,35,36,42,43,67,67,72,75,80,84, with out_last on 84.
  - Required: in_ready=1 again one cycle after that final handshake.
- Descending order with duplicates:
  - Load {5,5,1,9}, start with descending=1.
  - Required output: 9,5,5,1, with out_last on the 4th element.
- Full buffer and overflow:
  - Load 16 elements with values 16..1; in_ready must drop at count=16.
  - Then assert in_valid with 99 for 3 cycles: nothing is accepted and count stays 16.
  - Start ascending. Required output: 1..16.
- Degenerate counts:
  - start with count=0: no state change and busy stays 0.
  - Load the single value 7 and start: out_valid is asserted the next cycle with out_data=7 and out_last=1.
- Backpressure:
  - During DRAIN of {3,1,2}, hold out_ready=0 for 4 cycles.
  - Required: out_data holds 1 and out_valid holds 1 throughout; the output then completes as 1,2,3.
- Reset mid-operation:
  - Assert rst_n=0 in the 3rd cycle of SORT.
  - Required: immediately out_valid=0, busy=0, count=0, in_ready=1.
  - Required after release: a fresh load of {2,1} sorts to 1,2.

Source files
------------

// File: rtl/sort_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sort_buffer_if                                                   |
// | Brief   : Load/command/drain stream bundle for the sort buffer.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface sort_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              start;
    logic              descending;
    logic              busy;
    logic [CNT_W-1:0]  count;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, start, descending, out_ready,
        input  in_ready, busy, count, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, start, descending, out_ready,
        output in_ready, busy, count, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sort_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sort_buffer                                                      |
// | Brief   : Loads up to DEPTH words, odd-even transposition sorts them and   |
// |           drains them in ascending or descending order.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sort_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    sort_buffer_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_last_pass = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_mem      [DEPTH];
    logic [DATA_W-1:0] w_load_mem [DEPTH];
    logic [DATA_W-1:0] w_sorted   [DEPTH];

    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_pass;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_order;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;

    logic              w_wr_en;
    logic [CNT_W-1:0]  w_count_eff;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_rd_next;
    logic              w_pop;

    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_wr_en   = (r_state == S_LOAD) && bus.in_valid && (r_count < c_depth);
    // A write landing in the start cycle is part of the set being sorted.
    assign w_count_eff = r_count + CNT_W'(w_wr_en);
    assign w_pop       = (r_state == S_DRAIN) && bus.out_ready;

    always_comb begin
        w_load_mem = r_mem;
        if (w_wr_en) begin
            w_load_mem[w_wr_idx] = bus.in_data;
        end
    end

    // One transposition pass; pairs are disjoint so all read the old contents.
    always_comb begin
        w_sorted = r_mem;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if ((i % 2) == int'(r_pass[0]) && (CNT_W'(i + 1) < r_count)) begin
                if (r_order ? (r_mem[i] < r_mem[i+1]) : (r_mem[i] > r_mem[i+1])) begin
                    w_sorted[i]   = r_mem[i+1];
                    w_sorted[i+1] = r_mem[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (bus.start && (w_count_eff >= CNT_W'(2))) begin
                    w_state_nxt = S_SORT;
                end else if (bus.start && (w_count_eff == CNT_W'(1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_SORT: begin
                if (r_pass == c_last_pass) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_out_last) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Storage carries no reset: its contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && w_wr_en) begin
            r_mem[w_wr_idx] <= bus.in_data;
        end else if (r_state == S_SORT) begin
            r_mem <= w_sorted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_pass      <= '0;
            r_rd_ptr    <= '0;
            r_order     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_count <= w_count_eff;
                    if (bus.start && (w_count_eff >= CNT_W'(2))) begin
                        r_order <= bus.descending;
                        r_pass  <= '0;
                    end else if (bus.start && (w_count_eff == CNT_W'(1))) begin
                        r_rd_ptr    <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_load_mem[0];
                        r_out_last  <= 1'b1;
                    end
                end
                S_SORT: begin
                    r_pass <= r_pass + 1'b1;
                    if (r_pass == c_last_pass) begin
                        // The final pass result feeds the first output directly.
                        r_pass      <= '0;
                        r_rd_ptr    <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sorted[0];
                        r_out_last  <= (r_count == CNT_W'(1));
                    end
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        if (r_out_last) begin
                            r_count     <= '0;
                            r_rd_ptr    <= '0;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_rd_ptr   <= w_rd_next;
                            r_out_data <= r_mem[w_rd_next];
                            r_out_last <= ((CNT_W'(w_rd_next) + CNT_W'(1)) == r_count);
                        end
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_LOAD) && (r_count < c_depth);
    assign bus.busy      = (r_state != S_LOAD);
    assign bus.count     = r_count;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_sort_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sort_buffer                                                   |
// | Brief   : Directed self-checking bench for sort_buffer.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sort_buffer;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   cyc;
    logic [31:0] q_in  [$];
    logic [31:0] q_exp [$];

    sort_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sort_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_vals(input logic chk_ready);
        for (int i = 0; i < q_in.size(); i++) begin
            if (chk_ready) check("load_in_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = q_in[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic do_start(input logic dir);
        bus.start      = 1'b1;
        bus.descending = dir;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.descending = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!bus.out_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain_check(input string tag);
        int w;
        for (int k = 0; k < q_exp.size(); k++) begin
            wait_valid(w);
            check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_data"},  bus.out_data, q_exp[k]);
            check({tag, "_last"},  32'(bus.out_last), 32'(k == q_exp.size() - 1));
            @(negedge clk);
        end
        check({tag, "_in_ready_after"},  32'(bus.in_ready),  32'd1);
        check({tag, "_count_after"},     32'(bus.count),     32'd0);
        check({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        n_chk          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.start      = 1'b0;
        bus.descending = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_count",     32'(bus.count),     32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-burst load, ascending sort, fixed latency
        q_in = '{4, 80, 13, 27, 35, 67, 31, 43, 67, 42};
        load_vals(1'b1);
        check("t1_count10", 32'(bus.count), 32'd10);
        @(negedge clk);
        q_in = '{72, 75, 84, 36, 14};
        load_vals(1'b1);
        check("t1_count15", 32'(bus.count), 32'd15);
        do_start(1'b0);
        check("t1_busy_sort",     32'(bus.busy),     32'd1);
        check("t1_in_ready_sort", 32'(bus.in_ready), 32'd0);
        wait_valid(cyc);
        check("t1_latency", 32'(cyc), 32'd17);
        check("t1_count_drain", 32'(bus.count), 32'd15);
        q_exp = '{4, 13, 14, 27, 31, 35, 36, 42, 43, 67, 67, 72, 75, 80, 84};
        drain_check("t1");

        // Descending with duplicates
        q_in = '{5, 5, 1, 9};
        load_vals(1'b1);
        do_start(1'b1);
        q_exp = '{9, 5, 5, 1};
        drain_check("t2");

        // Full buffer and overflow attempts
        q_in = {};
        for (int v = 16; v >= 1; v--) q_in.push_back(32'(v));
        load_vals(1'b1);
        check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        check("t3_count_full",    32'(bus.count),    32'd16);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_count_overflow", 32'(bus.count), 32'd16);
        end
        bus.in_valid = 1'b0;
        do_start(1'b0);
        q_exp = {};
        for (int v = 1; v <= 16; v++) q_exp.push_back(32'(v));
        drain_check("t3");

        // Start with empty buffer is ignored
        do_start(1'b0);
        check("t4_empty_busy",      32'(bus.busy),      32'd0);
        check("t4_empty_in_ready",  32'(bus.in_ready),  32'd1);
        check("t4_empty_out_valid", 32'(bus.out_valid), 32'd0);

        // Single element skips the sort
        q_in = '{7};
        load_vals(1'b1);
        do_start(1'b0);
        check("t4_single_valid", 32'(bus.out_valid), 32'd1);
        check("t4_single_data",  bus.out_data,       32'd7);
        check("t4_single_last",  32'(bus.out_last),  32'd1);
        q_exp = '{7};
        drain_check("t4");

        // Backpressure holds the first output
        q_in = '{3, 1, 2};
        load_vals(1'b1);
        bus.out_ready = 1'b0;
        do_start(1'b0);
        wait_valid(cyc);
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t5_hold_data",  bus.out_data,       32'd1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        q_exp = '{1, 2, 3};
        drain_check("t5");

        // Reset in the third SORT cycle
        q_in = '{9, 8, 7};
        load_vals(1'b1);
        do_start(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t6_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_rst_busy",      32'(bus.busy),      32'd0);
        check("t6_rst_count",     32'(bus.count),     32'd0);
        check("t6_rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("t6_no_stale_output", 32'(bus.out_valid), 32'd0);
        end
        q_in = '{2, 1};
        load_vals(1'b1);
        do_start(1'b0);
        q_exp = '{1, 2};
        drain_check("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
